// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I decode definitions: the data width, the
//                immediate-format encoding and the immediate decoder.
//
//                imm_decode() maps instruction bits [31:7] and a format
//                select to the 32-bit immediate and a legal-format flag.
//                It is pure combinational logic. Any caller may reuse it,
//                including a golden model.
//
//  Revision    : 1.0  initial release
// ============================================================================
package rv32i_pkg;

   // Only 32-bit datapaths are supported.
   localparam int XLEN = 32;

   // Immediate format select. Codes 3'b101..3'b111 are reserved.
   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_type_e;

   // Decoder result: the immediate plus a flag for a legal format code.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] imm;
   } imm_result_t;

   // raw is indexed by instruction bit position, so each field below reads
   // the same way as the ISA encoding tables.
   // ins[31] is the sign bit for every format. U-type places the field
   // in the upper bits, so it needs no extension.
   function automatic imm_result_t imm_decode(input logic [31:7] raw,
                                              input logic [2:0]  imm_type);
      imm_result_t res;
      res.valid = 1'b0;
      res.imm   = '0;
      case (imm_type)
         IMM_I: begin
            res.valid = 1'b1;
            res.imm   = {{20{raw[31]}}, raw[31:20]};
         end
         IMM_S: begin
            res.valid = 1'b1;
            res.imm   = {{20{raw[31]}}, raw[31:25], raw[11:7]};
         end
         IMM_B: begin
            res.valid = 1'b1;
            res.imm   = {{19{raw[31]}}, raw[31], raw[7], raw[30:25],
                         raw[11:8], 1'b0};
         end
         IMM_J: begin
            res.valid = 1'b1;
            res.imm   = {{11{raw[31]}}, raw[31], raw[19:12], raw[20],
                         raw[30:21], 1'b0};
         end
         IMM_U: begin
            res.valid = 1'b1;
            res.imm   = {raw[31:12], 12'b0};
         end
         // Reserved codes, including X/Z on the select, decode to zero.
         // This default keeps the logic free of latches.
         default: begin
            res.valid = 1'b0;
            res.imm   = '0;
         end
      endcase
      return res;
   endfunction

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/sign_extend.sv
`default_nettype none
// ============================================================================
//  Module      : sign_extend
//  Description : RV32I immediate generator for the decode stage.
//                It produces the sign-extended immediate for the I, S, B,
//                J and U formats. The result is available two ways:
//                  * combinationally, for the ALU operand mux and the
//                    branch/jump target adder;
//                  * registered one cycle later, for pipelined datapaths.
//
//  Ports       :
//    clk             in   1   clock (registered outputs only)
//    rst             in   1   synchronous, active-high reset
//    raw_src         in  25   instruction bits [31:7]
//    imm_type        in   3   format select (000 I, 001 S, 010 B,
//                             011 J, 100 U, others reserved)
//    imm_produced    out 32   combinational immediate
//    imm_valid       out  1   combinational legal-format flag
//    imm_produced_q  out 32   imm_produced delayed by one clock
//    imm_valid_q     out  1   imm_valid delayed by one clock
//
//  Revision    : 1.0  initial release
// ============================================================================
module sign_extend #(
   // Width of the datapath. Only 32 is supported.
   parameter int XLEN = rv32i_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:7]     raw_src,
   input  logic [2:0]      imm_type,
   output logic [XLEN-1:0] imm_produced,
   output logic            imm_valid,
   output logic [XLEN-1:0] imm_produced_q,
   output logic            imm_valid_q
);

   import rv32i_pkg::*;

   imm_result_t     w_dec;
   logic [XLEN-1:0] r_imm;
   logic            r_valid;

   // Zero-latency decode. It does not depend on clk or rst.
   always_comb begin
      w_dec = imm_decode(raw_src, imm_type);
   end

   assign imm_produced = w_dec.imm;
   assign imm_valid    = w_dec.valid;

   // Pipeline copy. Reset clears only this register, on the edge where it
   // is asserted. The combinational path is unaffected.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_imm   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_imm   <= w_dec.imm;
         r_valid <= w_dec.valid;
      end
   end

   assign imm_produced_q = r_imm;
   assign imm_valid_q    = r_valid;

endmodule : sign_extend
`default_nettype wire

// File: tb/tb_sign_extend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sign_extend
//  Description : Self-checking bench for sign_extend. An arithmetic model
//                derives each immediate from field values weighted by
//                their bit positions. A negedge monitor compares every
//                output against that model on every cycle. Directed vectors
//                with literal answers pin both the DUT and the model.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sign_extend;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ins;
   logic [31:7] raw_src;
   logic [2:0]  imm_type;
   logic [31:0] imm_produced;
   logic        imm_valid;
   logic [31:0] imm_produced_q;
   logic        imm_valid_q;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q;
   logic        exp_vq;
   bit          q_known = 1'b0;

   assign raw_src = ins[31:7];

   always #5 clk = ~clk;

   sign_extend #(.XLEN(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .raw_src        (raw_src),
      .imm_type       (imm_type),
      .imm_produced   (imm_produced),
      .imm_valid      (imm_valid),
      .imm_produced_q (imm_produced_q),
      .imm_valid_q    (imm_valid_q)
   );

   // Returns {valid, imm}. Each field value is multiplied by the weight of
   // its position in the immediate. The sign is applied as -1 or 0 times
   // the weight of the first bit above the field.
   function automatic logic [32:0] model(input logic [31:0] i, input logic [2:0] t);
      int s, sg, r;
      int f_a, f_b, f_c, f_d;
      s  = i;
      sg = s >>> 31;            // 0 or -1
      r  = 0;
      case (t)
         3'd0: begin
            r = s >>> 20;
         end
         3'd1: begin
            f_a = i[11:7];
            r   = (s >>> 25) * 32 + f_a;
         end
         3'd2: begin
            f_a = i[7];
            f_b = i[30:25];
            f_c = i[11:8];
            r   = sg * 4096 + f_a * 2048 + f_b * 32 + f_c * 2;
         end
         3'd3: begin
            f_a = i[19:12];
            f_b = i[20];
            f_c = i[30:21];
            f_d = sg * 1048576;
            r   = f_d + f_a * 4096 + f_b * 2048 + f_c * 2;
         end
         3'd4: begin
            r = s & 32'hFFFFF000;
         end
         default: r = 0;
      endcase
      return {(t <= 3'd4), 32'(r)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Expected registered outputs, captured from the same edge the DUT sees.
   always @(posedge clk) begin
      logic [32:0] m;
      m = model(ins, imm_type);
      if (rst) begin
         exp_q  = '0;
         exp_vq = 1'b0;
      end else begin
         exp_q  = m[31:0];
         exp_vq = m[32];
      end
      q_known = 1'b1;
   end

   // Every-cycle monitor. It runs mid-cycle, away from the active edge.
   always @(negedge clk) begin
      logic [32:0] m;
      m = model(ins, imm_type);
      chk("mon_imm", imm_produced, m[31:0]);
      chk("mon_valid", {31'b0, imm_valid}, {31'b0, m[32]});
      if (q_known) begin
         chk("mon_imm_q", imm_produced_q, exp_q);
         chk("mon_valid_q", {31'b0, imm_valid_q}, {31'b0, exp_vq});
      end
   end

   task automatic directed(input string name, input logic [31:0] i, input logic [2:0] t,
                           input logic [31:0] exp_imm, input logic exp_v);
      logic [32:0] m;
      @(posedge clk);
      #2;
      ins      = i;
      imm_type = t;
      #1;
      chk(name, imm_produced, exp_imm);
      chk({name, "_valid"}, {31'b0, imm_valid}, {31'b0, exp_v});
      m = model(i, t);
      chk({name, "_model"}, m[31:0], exp_imm);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected end before 2ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      ins      = '1;
      imm_type = 3'd0;

      // Reset held for one edge clears the pipeline copy.
      @(posedge clk);
      #1;
      chk("reset_imm_q", imm_produced_q, 32'h0);
      chk("reset_valid_q", {31'b0, imm_valid_q}, 32'h0);

      // I-type 123, then one edge later in the register.
      #1;
      rst      = 1'b0;
      ins      = 32'd123 << 20;
      imm_type = 3'd0;
      @(posedge clk);
      #1;
      chk("reg_i123_q", imm_produced_q, 32'h0000007B);
      chk("reg_i123_valid_q", {31'b0, imm_valid_q}, 32'h1);

      directed("i_pos",       32'h07B00000, 3'd0, 32'h0000007B, 1'b1);
      directed("i_neg",       32'hF8500000, 3'd0, 32'hFFFFFF85, 1'b1);
      directed("s_min",       32'h80000000, 3'd1, 32'hFFFFF800, 1'b1);
      directed("s_max",       32'h7E000F80, 3'd1, 32'h000007FF, 1'b1);
      directed("s_min_noise", 32'h81FFF000, 3'd1, 32'hFFFFF800, 1'b1);
      directed("s_max_noise", 32'h7FFFFF80, 3'd1, 32'h000007FF, 1'b1);
      directed("b_sign",      32'h80000000, 3'd2, 32'hFFFFF000, 1'b1);
      directed("b_bit7",      32'h00000080, 3'd2, 32'h00000800, 1'b1);
      directed("b_11_8",      32'h00000F00, 3'd2, 32'h0000001E, 1'b1);
      directed("j_sign",      32'h80000000, 3'd3, 32'hFFF00000, 1'b1);
      directed("j_bit20",     32'h00100000, 3'd3, 32'h00000800, 1'b1);
      directed("j_19_12",     32'h000FF000, 3'd3, 32'h000FF000, 1'b1);
      directed("u_basic",     32'hABCDE000, 3'd4, 32'hABCDE000, 1'b1);
      directed("u_noise",     32'hABCDEF80, 3'd4, 32'hABCDE000, 1'b1);
      directed("illegal_101", 32'hFFFFFFFF, 3'd5, 32'h00000000, 1'b0);
      directed("illegal_110", 32'hFFFFFFFF, 3'd6, 32'h00000000, 1'b0);
      directed("illegal_111", 32'hFFFFFFFF, 3'd7, 32'h00000000, 1'b0);

      // Reset asserted mid-stream clears only the register.
      @(posedge clk);
      #2;
      ins      = 32'hFFF00000;
      imm_type = 3'd0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_imm_q", imm_produced_q, 32'h0);
      chk("midrst_comb", imm_produced, 32'hFFFFFFFF);
      #1;
      rst = 1'b0;

      // Random vectors: 500 per legal format plus some reserved codes.
      // A rare reset exercises the register path under traffic.
      for (int t = 0; t < 6; t++) begin
         for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            #2;
            ins      = $urandom;
            imm_type = (t == 5) ? 3'($urandom_range(5, 7)) : 3'(t);
            rst      = ($urandom_range(0, 49) == 0);
         end
      end

      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_sign_extend
`default_nettype wire
